// File: rtl/mul_unit.sv
// RV32M multiplier (MUL/MULH/MULHSU/MULHU): radix-2 shift-add, one partial product per cycle.
// Operands are reduced to magnitudes on accept; the sign is reapplied once in FIX.
module mul_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic             neg_q;
  logic [WIDTH-1:0] mcand;
  logic [PW-1:0]    prod;
  logic [CW-1:0]    cnt;

  logic             sa_c;
  logic             sb_c;
  logic             neg_c;
  logic [WIDTH-1:0] a_abs_c;
  logic [WIDTH-1:0] b_abs_c;
  logic [WIDTH:0]   sum_c;
  logic [PW-1:0]    fixed_c;

  // Operand sign handling, iteration adder and final sign correction.
  always_comb begin
    sa_c    = (op == 2'b01) || (op == 2'b10);
    sb_c    = (op == 2'b01);
    neg_c   = (sa_c & a[WIDTH-1]) ^ (sb_c & b[WIDTH-1]);
    a_abs_c = (sa_c && a[WIDTH-1]) ? -a : a;
    b_abs_c = (sb_c && b[WIDTH-1]) ? -b : b;
    sum_c   = {1'b0, prod[PW-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    fixed_c = neg_q ? -prod : prod;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      mcand  <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            op_q  <= op;
            neg_q <= neg_c;
            mcand <= a_abs_c;
            prod  <= {{WIDTH{1'b0}}, b_abs_c};
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // Carry, accumulator and remaining multiplier bits shift right as one chain.
          prod <= {sum_c, prod[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          result <= (op_q == 2'b00) ? fixed_c[WIDTH-1:0] : fixed_c[PW-1:WIDTH];
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
